mem_access_unit: RTL

MEM-stage access controller sitting directly upstream of the word-addressed data memory. It takes byte-addressed load/store requests from the EX/MEM pipeline register and drives the memory's single read/write port. It performs byte-lane extraction with sign/zero extension for loads, and a two-cycle read-modify-write for sub-word stores, stalling the pipeline for one cycle. It flags misaligned accesses instead of issuing them.

---
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: byte-lane loads with extension, word stores,
// and two-cycle read-modify-write for sub-word stores into a word-addressed memory.
//
// state  | meaning
// IDLE   | accepting requests; loads, word stores and the RMW read issue here
// RMW_WR | writing the latched merged word back; request inputs ignored
module mem_access_unit #(
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_req_valid,
  input  logic                   i_req_we,
  input  logic [1:0]             i_req_size,
  input  logic                   i_req_unsigned,
  input  logic [ADDR_SIZE+1:0]   i_req_addr,
  input  logic [DATA_SIZE-1:0]   i_req_wdata,
  output logic                   o_stall,
  output logic [DATA_SIZE-1:0]   o_rdata,
  output logic                   o_rdata_valid,
  output logic                   o_misaligned,
  output logic                   o_mem_wr_rd,
  output logic [ADDR_SIZE-1:0]   o_mem_addr,
  output logic [DATA_SIZE-1:0]   o_mem_data,
  input  logic [DATA_SIZE-1:0]   i_mem_data
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                 state;
  logic [ADDR_SIZE-1:0]   rmw_addr;
  logic [DATA_SIZE-1:0]   rmw_data;

  logic                   clear;
  logic [ADDR_SIZE-1:0]   word_addr;
  logic [1:0]             byte_off;
  logic                   legal;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [DATA_SIZE-1:0]   ld_value;
  logic [DATA_SIZE-1:0]   merged;

  assign clear     = i_reset | i_flush;
  assign word_addr = i_req_addr[ADDR_SIZE+1:2];
  assign byte_off  = i_req_addr[1:0];

  always_comb begin
    case (i_req_size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~byte_off[0];
      2'b10:   legal = (byte_off == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (byte_off)
      2'd0:    ld_byte = i_mem_data[7:0];
      2'd1:    ld_byte = i_mem_data[15:8];
      2'd2:    ld_byte = i_mem_data[23:16];
      default: ld_byte = i_mem_data[31:24];
    endcase
    ld_half = byte_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    case (i_req_size)
      2'b00:   ld_value = i_req_unsigned ? {{(DATA_SIZE-8){1'b0}}, ld_byte}
                                         : {{(DATA_SIZE-8){ld_byte[7]}}, ld_byte};
      2'b01:   ld_value = i_req_unsigned ? {{(DATA_SIZE-16){1'b0}}, ld_half}
                                         : {{(DATA_SIZE-16){ld_half[15]}}, ld_half};
      default: ld_value = i_mem_data;
    endcase
  end

  // Merged word for a sub-word store: current memory word with one lane replaced.
  always_comb begin
    merged = i_mem_data;
    if (i_req_size == 2'b00) begin
      case (byte_off)
        2'd0:    merged[7:0]   = i_req_wdata[7:0];
        2'd1:    merged[15:8]  = i_req_wdata[7:0];
        2'd2:    merged[23:16] = i_req_wdata[7:0];
        default: merged[31:24] = i_req_wdata[7:0];
      endcase
    end else if (byte_off[1]) begin
      merged[31:16] = i_req_wdata[15:0];
    end else begin
      merged[15:0] = i_req_wdata[15:0];
    end
  end

  always_comb begin
    o_mem_wr_rd = 1'b0;
    o_mem_addr  = '0;
    o_mem_data  = '0;
    o_stall     = 1'b0;
    if (!clear) begin
      if (state == RMW_WR) begin
        o_mem_wr_rd = 1'b1;
        o_mem_addr  = rmw_addr;
        o_mem_data  = rmw_data;
      end else if (i_req_valid && legal) begin
        o_mem_addr = word_addr;
        if (i_req_we) begin
          if (i_req_size == 2'b10) begin
            o_mem_wr_rd = 1'b1;
            o_mem_data  = i_req_wdata;
          end else begin
            o_stall = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (clear) begin
      state         <= IDLE;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_misaligned  <= 1'b0;
      rmw_addr      <= '0;
      rmw_data      <= '0;
    end else begin
      o_rdata_valid <= 1'b0;
      o_misaligned  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            if (!legal) begin
              o_misaligned <= 1'b1;
            end else if (!i_req_we) begin
              o_rdata       <= ld_value;
              o_rdata_valid <= 1'b1;
            end else if (i_req_size != 2'b10) begin
              rmw_data <= merged;
              rmw_addr <= word_addr;
              state    <= RMW_WR;
            end
          end
        end
        RMW_WR: state <= IDLE;
      endcase
    end
  end

endmodule
